gwa_dispense_ctrl: RTL
======================

# gwa_dispense_ctrl

Output-side actuator controller for the drinks vending machine. It accepts the single-cycle command pulses issued by the vending-machine FSM (dispense 1.00/2.00 product, return 1 € / 2 € coin) and queues them in a small command FIFO. It replays each command as a timed solenoid drive pulse, optionally confirmed by a mechanism sensor. It sits between the vending FSM and the physical ejector/coin-return hardware.

## Interface
- FIFO_DEPTH, 4, command queue entries (power of two, ≥2)
- PULSE_CYC, 8, cycles a drive output stays high per command (≥1)
- GAP_CYC, 4, idle cycles enforced after each command (≥1)
- TMO_CYC, 64, max cycles waiting for sensor ack (used only with GWA_DISP_TIMEOUT_EN)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- c10_req  in  1  dispense product, price 1 € (pulse)
- c20_req  in  1  dispense product, price 2 € (pulse)
- eu1_ret  in  1  return one 1 € coin (pulse)
- eu2_ret  in  1  return one 2 € coin (pulse)
- sens_done  in  1  mechanism completion sensor, level or pulse
- err_clr  in  1  clears sticky error flags
- drv_c10, drv_c20, drv_eu1, drv_eu2  out  1 each  solenoid drives, at most one high
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- ovf_err  out  1  sticky: command dropped on full FIFO
- multi_err  out  1  sticky: more than one request in one cycle
- tmo_err  out  1  sticky: sensor timeout
- disp_cnt  out  8  completed commands, wraps 255→0

## Operation
- Reset: all outputs 0, FIFO empty, FSM IDLE, counters 0. Asserting rst mid-drive drops the drive output immediately, without waiting for a clock edge. Queued commands are discarded.
- Enqueue: on each rising edge, any asserted request is encoded and pushed.
- Multiple requests in the same cycle: only the highest-priority request is pushed, in the order c20 > c10 > eu2 > eu1. Sets multi_err.
- Full FIFO with no pop in the same cycle: the request is dropped and ovf_err is set. A push and pop in the same cycle on a full FIFO are both accepted.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and go to DRIVE. The matching drv_* goes high from that edge.
  - DRIVE: hold drv_* for exactly PULSE_CYC cycles. Then go to WAIT_ACK (macro defined) or GAP (macro undefined).
  - WAIT_ACK: all drives low. sens_done=1 goes to GAP. Reaching TMO_CYC cycles without ack sets tmo_err and goes to GAP.
  - GAP: all drives low for GAP_CYC cycles, then IDLE.
- disp_cnt increments on each entry into GAP, including after a timeout.
- err_clr clears all three sticky flags. If a new error event occurs in the same cycle, the set wins.
- sens_done is ignored outside WAIT_ACK.

## Timing
- Request sampled at edge k → drv_* high after edge k+1 (2-cycle latency from an idle, empty state).
- Back-to-back commands (macro undefined): drive periods start PULSE_CYC+GAP_CYC+1 cycles apart. The extra cycle is spent in IDLE.
- With the macro defined, sens_done sampled at edge j in WAIT_ACK → GAP entered at edge j. Timeout is reached after exactly TMO_CYC cycles in WAIT_ACK.
- fifo_full and the error flags are registered and update on the edge that causes the event.

## Configuration
- GWA_DISP_TIMEOUT_EN defined:
  - WAIT_ACK state, ack counter and tmo_err logic are present.
  - Each command completes on sens_done or after TMO_CYC cycles.
- GWA_DISP_TIMEOUT_EN undefined:
  - No WAIT_ACK state; DRIVE goes directly to GAP.
  - sens_done is unused and tmo_err is tied to 0.

## Structure
- Package gwa_pkg holds:
  - 2-bit command typedef: CMD_EU1=0, CMD_EU2=1, CMD_C10=2, CMD_C20=3.
  - FSM state enum.
  - Default parameter constants.
- Sub-module gwa_cmd_fifo: synchronous FIFO, width 2, depth FIFO_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Pointers with wrap bit; async reset to empty.
- The top level contains the request priority encoder, the FSM, the cycle counter (sized for max(PULSE_CYC, GAP_CYC, TMO_CYC)), the flags and disp_cnt.

## Test plan
- Single c20_req pulse at cycle 5, macro undefined → drv_c20 high cycles 7–14; busy falls after the GAP; disp_cnt=1.
- Five eu1_ret pulses on consecutive cycles, FIFO_DEPTH=4, idle start → first pulse popped at the next edge, other four queued, none dropped, ovf_err=0, five drv_eu1 pulses. A sixth pulse while 4 entries are queued → ovf_err=1, and only the first five are dispensed.
- c10_req and eu2_ret in the same cycle → only drv_c10 fires; multi_err=1. err_clr pulse → multi_err=0.
- Macro defined, sens_done never asserted → tmo_err=1 exactly TMO_CYC cycles after the drive ends; next command still executes.
- Macro defined, sens_done asserted during DRIVE only → ignored; sens_done in the 3rd WAIT_ACK cycle → GAP entered, tmo_err stays 0.
- rst asserted in the 3rd DRIVE cycle with 2 commands queued → drive drops immediately; after release busy=0, disp_cnt=0, no further drives.

Source files
------------

// File: rtl/gwa_pkg.sv
// gwa_pkg: shared types and default constants for the vending-machine
// actuator controller (gwa_dispense_ctrl and its command FIFO).
//   cmd_t    - 2-bit encoded actuator command stored in the FIFO
//   state_t  - dispense FSM states
//   DEF_*    - default parameter values
//   max3     - helper used to size the shared cycle counter
package gwa_pkg;

  typedef enum logic [1:0] {
    CMD_EU1 = 2'd0,
    CMD_EU2 = 2'd1,
    CMD_C10 = 2'd2,
    CMD_C20 = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRIVE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_PULSE_CYC  = 8;
  localparam int DEF_GAP_CYC    = 4;
  localparam int DEF_TMO_CYC    = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gwa_dispense_ctrl_fifo.sv
// gwa_cmd_fifo: synchronous command FIFO, 2-bit wide, DEPTH entries.
// Read/write pointers carry an extra wrap bit so full and empty are
// distinguished without a separate occupancy counter.
//   clk, rst   - clock, asynchronous active-high reset (to empty)
//   push, din  - write request and data; ignored when full unless popping
//   pop, dout  - read request; dout always shows the head entry
//   full       - DEPTH entries held
//   empty      - no entries held
module gwa_cmd_fifo
  import gwa_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push on a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gwa_dispense_ctrl.sv
// gwa_dispense_ctrl: actuator controller for the drinks vending machine.
// Queues single-cycle commands from the vending FSM and replays each as a
// PULSE_CYC-cycle solenoid drive followed by a GAP_CYC-cycle quiet period.
//
// Optional feature macro: GWA_DISP_TIMEOUT_EN
//   defined   - after each drive, wait for sens_done (up to TMO_CYC cycles,
//               tmo_err on expiry) before the gap
//   undefined - drive goes straight to the gap; sens_done unused, tmo_err=0
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   c10_req, c20_req         - dispense product (1 EUR / 2 EUR), pulses
//   eu1_ret, eu2_ret         - return a 1 EUR / 2 EUR coin, pulses
//   sens_done                - mechanism completion sensor
//   err_clr                  - clears the sticky error flags
//   drv_c10/c20/eu1/eu2      - solenoid drives, at most one high
//   busy                     - command in progress or queued
//   fifo_full                - command queue full
//   ovf_err, multi_err, tmo_err - sticky error flags
//   disp_cnt                 - completed commands, wraps
//
// FSM states:
//   ST_IDLE     | waiting for a queued command; pops head when non-empty
//   ST_DRIVE    | matching drv_* high for PULSE_CYC cycles
//   ST_WAIT_ACK | drives low, waiting for sens_done or TMO_CYC timeout
//   ST_GAP      | drives low for GAP_CYC cycles before next command
module gwa_dispense_ctrl
  import gwa_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int TMO_CYC    = DEF_TMO_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c10_req,
  input  logic       c20_req,
  input  logic       eu1_ret,
  input  logic       eu2_ret,
  input  logic       sens_done,
  input  logic       err_clr,
  output logic       drv_c10,
  output logic       drv_c20,
  output logic       drv_eu1,
  output logic       drv_eu2,
  output logic       busy,
  output logic       fifo_full,
  output logic       ovf_err,
  output logic       multi_err,
  output logic       tmo_err,
  output logic [7:0] disp_cnt
);

  localparam int CW = $clog2(max3(PULSE_CYC, GAP_CYC, TMO_CYC) + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  cmd_t          cur_cmd, cmd_nxt;

  logic   req_any;
  logic   req_multi;
  logic [2:0] req_num;
  cmd_t   req_cmd;
  logic   fifo_pop;
  logic   fifo_push;
  logic   fifo_empty;
  cmd_t   fifo_dout;
  logic   ovf_evt;
  logic   enter_gap;
  logic   tmo_evt;

  // Priority encoder: c20 > c10 > eu2 > eu1.
  always_comb begin
    req_num   = {2'b00, c10_req} + {2'b00, c20_req} +
                {2'b00, eu1_ret} + {2'b00, eu2_ret};
    req_any   = (req_num != 3'd0);
    req_multi = (req_num > 3'd1);
    if (c20_req)      req_cmd = CMD_C20;
    else if (c10_req) req_cmd = CMD_C10;
    else if (eu2_ret) req_cmd = CMD_EU2;
    else              req_cmd = CMD_EU1;
  end

  assign fifo_push = req_any;
  assign ovf_evt   = req_any && fifo_full && !fifo_pop;

  gwa_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (req_cmd),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cur_cmd <= CMD_EU1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur_cmd <= cmd_nxt;
    end
  end

  // cnt is a down-counter loaded with (length-1) on state entry; the state
  // is left on the edge after it reaches zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = cur_cmd;
    fifo_pop  = 1'b0;
    enter_gap = 1'b0;
    tmo_evt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cmd_nxt   = fifo_dout;
          cnt_nxt   = CW'(PULSE_CYC - 1);
          state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt == '0) begin
`ifdef GWA_DISP_TIMEOUT_EN
          cnt_nxt   = CW'(TMO_CYC - 1);
          state_nxt = ST_WAIT_ACK;
`else
          cnt_nxt   = CW'(GAP_CYC - 1);
          enter_gap = 1'b1;
          state_nxt = ST_GAP;
`endif
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
`ifdef GWA_DISP_TIMEOUT_EN
      ST_WAIT_ACK: begin
        if (sens_done) begin
          cnt_nxt   = CW'(GAP_CYC - 1);
          enter_gap = 1'b1;
          state_nxt = ST_GAP;
        end else if (cnt == '0) begin
          cnt_nxt   = CW'(GAP_CYC - 1);
          enter_gap = 1'b1;
          tmo_evt   = 1'b1;
          state_nxt = ST_GAP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
`endif
      ST_GAP: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Drives decode straight from async-reset flops so rst drops them at once.
  assign drv_c10 = (state == ST_DRIVE) && (cur_cmd == CMD_C10);
  assign drv_c20 = (state == ST_DRIVE) && (cur_cmd == CMD_C20);
  assign drv_eu1 = (state == ST_DRIVE) && (cur_cmd == CMD_EU1);
  assign drv_eu2 = (state == ST_DRIVE) && (cur_cmd == CMD_EU2);
  assign busy    = (state != ST_IDLE) || !fifo_empty;

  // Sticky flags: a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err   <= 1'b0;
      multi_err <= 1'b0;
      disp_cnt  <= 8'd0;
    end else begin
      if (ovf_evt)      ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
      if (req_multi)    multi_err <= 1'b1;
      else if (err_clr) multi_err <= 1'b0;
      if (enter_gap)    disp_cnt <= disp_cnt + 8'd1;
    end
  end

`ifdef GWA_DISP_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tmo_err <= 1'b0;
    else if (tmo_evt) tmo_err <= 1'b1;
    else if (err_clr) tmo_err <= 1'b0;
  end
`else
  logic unused_tmo;
  assign unused_tmo = sens_done ^ tmo_evt;
  assign tmo_err    = 1'b0;
`endif

endmodule
